// File: rtl/bcd_tick_counter.sv
// ---------------------------------------------------------------------------
// bcd_tick_counter
//
// Two-digit BCD event counter, enabled by the rising edges of a divided
// square wave (div_clk). Everything runs in the single clk domain; div_clk
// is only ever sampled as data. A debounced active-low pushbutton toggles
// between RUN and PAUSE. Counts COUNT_MIN..COUNT_MAX and wraps.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   div_clk      divided square wave; one count per rising edge
//   pause_btn_n  debounced active-low button; falling edge toggles run/pause
//   clear        synchronous, level-sensitive clear to COUNT_MIN
//   ones, tens   BCD digits of the current count
//   hex0, hex1   registered active-low 7-segment codes (bit6=g .. bit0=a)
//   running      1 = RUN, 0 = PAUSE
//   wrap         one-cycle pulse coincident with the COUNT_MAX -> COUNT_MIN load
// ---------------------------------------------------------------------------
module bcd_tick_counter #(
  parameter int COUNT_MIN = 1,
  parameter int COUNT_MAX = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       div_clk,
  input  logic       pause_btn_n,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] MIN_ONES = 4'(COUNT_MIN % 10);
  localparam logic [3:0] MIN_TENS = 4'(COUNT_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(COUNT_MAX % 10);
  localparam logic [3:0] MAX_TENS = 4'(COUNT_MAX / 10);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  state_t state;

  // Active-low seven-segment decode; codes 10-15 blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  // -------------------------------------------------------------------------
  // Synchronizers with a history stage for edge detection
  // -------------------------------------------------------------------------
  logic s1, s2, s3;
  logic b1, b2, b3;
  logic step;
  logic press;

  // NOTE: every flop here uses non-blocking assignment so all stages sample
  // the pre-edge values; blocking would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Preset to 1: a high div_clk (or released button) at reset release
      // then looks like a steady level, not a fresh edge, and any edge still
      // in flight is dropped.
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      b1 <= 1'b1;
      b2 <= 1'b1;
      b3 <= 1'b1;
    end else begin
      s1 <= div_clk;
      s2 <= s1;
      s3 <= s2;
      b1 <= pause_btn_n;
      b2 <= b1;
      b3 <= b2;
    end
  end

  assign step  = s2 & ~s3;
  assign press = ~b2 & b3;

  // -------------------------------------------------------------------------
  // Run/pause state machine
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else if (press) begin
      state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  assign running = (state == ST_RUN);

  // -------------------------------------------------------------------------
  // BCD counter. The step is qualified with the state as it was before any
  // toggle in the same cycle, so RUN+press+step still counts.
  // -------------------------------------------------------------------------
  logic at_max;
  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

  always_ff @(posedge clk) begin
    if (reset) begin
      ones <= MIN_ONES;
      tens <= MIN_TENS;
      wrap <= 1'b0;
    end else begin
      // NOTE: default first, override below; the last non-blocking
      // assignment in the block wins, so wrap is a clean one-cycle pulse.
      wrap <= 1'b0;
      if (clear) begin
        ones <= MIN_ONES;
        tens <= MIN_TENS;
      end else if (step && (state == ST_RUN)) begin
        if (at_max) begin
          ones <= MIN_ONES;
          tens <= MIN_TENS;
          wrap <= 1'b1;
        end else if (ones == 4'd9) begin
          ones <= 4'd0;
          tens <= tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
      end
    end
  end

  // Display registers trail the digits by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex0 <= seg7(MIN_ONES);
      hex1 <= seg7(MIN_TENS);
    end else begin
      hex0 <= seg7(ones);
      hex1 <= seg7(tens);
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_tick_counter
//
// Self-checking bench for bcd_tick_counter. A behavioural model tracks the
// count as a plain integer: a div_clk rising edge first seen at clock edge k
// is counted at edge k+2, a button falling edge toggles run/pause at the same
// latency, and the displays show the previous cycle's digits. A compare
// process checks every output on every falling clock edge; directed
// literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_bcd_tick_counter;

  localparam int COUNT_MIN = 1;
  localparam int COUNT_MAX = 99;

  logic       clk = 1'b0;
  logic       reset;
  logic       div_clk;
  logic       pause_btn_n;
  logic       clear;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic       running;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_tick_counter #(
    .COUNT_MIN(COUNT_MIN),
    .COUNT_MAX(COUNT_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .div_clk    (div_clk),
    .pause_btn_n(pause_btn_n),
    .clear      (clear),
    .ones       (ones),
    .tens       (tens),
    .hex0       (hex0),
    .hex1       (hex1),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  int   m_count;
  bit   m_run;
  bit   m_wrap;
  logic [6:0] m_hex0, m_hex1;
  bit   m_valid = 0;
  // Input levels sampled at the previous three clock edges (0 = most recent).
  bit   dv [3];
  bit   pb [3];

  always @(posedge clk) begin
    bit m_step, m_press;
    if (reset) begin
      m_count = COUNT_MIN;
      m_run   = 1;
      m_wrap  = 0;
      m_hex0  = seg(COUNT_MIN % 10);
      m_hex1  = seg(COUNT_MIN / 10);
      for (int i = 0; i < 3; i++) begin
        dv[i] = 1;
        pb[i] = 1;
      end
      m_valid = 1;
    end else if (m_valid) begin
      // Rising edge first seen two edges ago counts now.
      m_step  = dv[1] && !dv[2];
      m_press = !pb[1] && pb[2];
      m_hex0  = seg(m_count % 10);
      m_hex1  = seg(m_count / 10);
      m_wrap  = 0;
      if (clear) begin
        m_count = COUNT_MIN;
      end else if (m_step && m_run) begin
        if (m_count == COUNT_MAX) begin
          m_count = COUNT_MIN;
          m_wrap  = 1;
        end else begin
          m_count = m_count + 1;
        end
      end
      if (m_press) m_run = !m_run;
      dv[2] = dv[1]; dv[1] = dv[0]; dv[0] = div_clk;
      pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = pause_btn_n;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ones",    int'(ones),    m_count % 10);
      check("tens",    int'(tens),    m_count / 10);
      check("hex0",    int'(hex0),    int'(m_hex0));
      check("hex1",    int'(hex1),    int'(m_hex1));
      check("running", int'(running), int'(m_run));
      check("wrap",    int'(wrap),    int'(m_wrap));
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic div_edges(input int num, input int half);
    for (int i = 0; i < num; i++) begin
      div_clk = 1'b1;
      tick(half);
      div_clk = 1'b0;
      tick(half);
    end
  endtask

  task automatic press_btn();
    pause_btn_n = 1'b0;
    tick(4);
    pause_btn_n = 1'b1;
    tick(3);
  endtask

  task automatic step_with_clear();
    div_clk = 1'b1;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    div_clk     = 1'b0;
    pause_btn_n = 1'b1;
    clear       = 1'b0;

    // 1: reset with div_clk toggling, release with div_clk high
    for (int i = 0; i < 3; i++) begin
      div_clk = ~div_clk;
      tick(1);
    end
    check("rst_ones", int'(ones), 1);
    check("rst_tens", int'(tens), 0);
    check("rst_running", int'(running), 1);
    check("rst_wrap", int'(wrap), 0);
    div_clk = 1'b1;
    reset   = 1'b0;
    tick(1);
    check("rst_hex1", int'(hex1), 'h40);
    check("rst_hex0", int'(hex0), 'h79);
    tick(5);
    check("no_spurious_step", int'(ones), 1);
    div_clk = 1'b0;
    tick(3);

    // 2: single-edge latency, then 9 more edges at period 20
    div_clk = 1'b1;
    tick(1);
    check("lat_k_ones", int'(ones), 1);
    tick(1);
    check("lat_k1_ones", int'(ones), 1);
    tick(1);
    check("lat_k2_ones", int'(ones), 2);
    check("lat_k2_hex0", int'(hex0), 'h79);
    tick(1);
    check("lat_k3_hex0", int'(hex0), 'h24);
    tick(6);
    div_clk = 1'b0;
    tick(10);
    div_edges(9, 10);
    check("ten_edges_tens", int'(tens), 1);
    check("ten_edges_ones", int'(ones), 1);

    // 3: clear to 01, count to 99, then wrap
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_ones", int'(ones), 1);
    div_edges(98, 2);
    check("at99_tens", int'(tens), 9);
    check("at99_ones", int'(ones), 9);
    check("at99_hex1", int'(hex1), 'h10);
    check("at99_hex0", int'(hex0), 'h10);
    div_clk = 1'b1;
    tick(2);
    check("prewrap_wrap", int'(wrap), 0);
    check("prewrap_ones", int'(ones), 9);
    tick(1);
    check("wrap_pulse", int'(wrap), 1);
    check("wrap_ones", int'(ones), 1);
    check("wrap_tens", int'(tens), 0);
    tick(1);
    check("wrap_drop", int'(wrap), 0);
    div_clk = 1'b0;
    tick(2);

    // 4: pause at 05, ignored edges, resume
    div_edges(4, 2);
    check("at05_ones", int'(ones), 5);
    press_btn();
    check("paused", int'(running), 0);
    div_edges(3, 2);
    tick(2);
    check("paused_hold", int'(ones), 5);
    press_btn();
    check("resumed", int'(running), 1);
    check("resumed_hold", int'(ones), 5);
    div_edges(1, 2);
    check("after_resume", int'(ones), 6);

    // 5: clear coincident with a step, running and paused
    div_edges(36, 2);
    check("at42_tens", int'(tens), 4);
    check("at42_ones", int'(ones), 2);
    step_with_clear();
    check("clr_step_ones", int'(ones), 1);
    check("clr_step_tens", int'(tens), 0);
    check("clr_step_wrap", int'(wrap), 0);
    check("clr_step_run", int'(running), 1);
    div_clk = 1'b0;
    tick(3);
    div_edges(2, 2);
    check("at03", int'(ones), 3);
    press_btn();
    step_with_clear();
    check("clr_paused_ones", int'(ones), 1);
    check("clr_paused_run", int'(running), 0);
    div_clk = 1'b0;
    tick(3);
    press_btn();

    // 6: fastest div_clk, 20 rising edges from 01
    check("fast_start", int'(ones), 1);
    for (int i = 0; i < 40; i++) begin
      div_clk = ~div_clk;
      tick(1);
    end
    tick(4);
    check("fast_tens", int'(tens), 2);
    check("fast_ones", int'(ones), 1);

    // Reset mid-flight: the edge in the synchronizer is dropped
    div_clk = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_ones", int'(ones), 1);
    check("midrst_tens", int'(tens), 0);
    check("midrst_run", int'(running), 1);
    tick(4);
    check("midrst_dropped", int'(ones), 1);
    div_clk = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
